// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment capture path: segment codes
// (ABCDEFG, active-low), digit count and the frame state encoding.
package seven_seg_pkg;

    localparam int DIGITS = 4;
    localparam int SMP_W  = DIGITS + 7;

    // Idle bus: every anode off, every segment off.
    localparam logic [SMP_W-1:0] SMP_IDLE = {SMP_W{1'b1}};

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    typedef enum logic {
        SCAN,
        DONE
    } frame_state_t;

endpackage

// File: rtl/seven_seg_pattern_lookup.sv
// Inverse of the hex-to-segment encoder: maps an active-low ABCDEFG
// pattern back to its nibble and flags patterns outside the code table.
module seven_seg_pattern_lookup
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        case (pattern)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Display-bus monitor: debounces {an_n, seg_n}, decodes accepted patterns
// into per-digit nibbles and pulses frame_valid once every digit refreshed.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_n,
    input  logic [DIGITS-1:0]   an_n,
    input  logic                clr,
    output logic [4*DIGITS-1:0] digits,
    output logic [DIGITS-1:0]   digit_valid,
    output logic [4*DIGITS-1:0] frame,
    output logic                frame_valid,
    output logic                code_err,
    output logic                anode_err
);

    localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

    logic [SMP_W-1:0]    sample_in;
    logic [SMP_W-1:0]    smp_reg;
    logic [7:0]          cnt_reg, cnt_next;
    logic                accept_reg, accept_next;

    logic [DIGITS-1:0]   an_low;
    logic                multi_low, single_low;
    logic                accept_act, single_act;
    logic                code_legal;
    logic [3:0]          code_nibble;
    logic [DIGITS-1:0]   digit_hit;

    logic [4*DIGITS-1:0] digits_reg, digits_next;
    logic [DIGITS-1:0]   digit_valid_reg, digit_valid_next;
    logic [4*DIGITS-1:0] frame_reg, frame_next;
    logic                frame_valid_reg, code_err_reg, anode_err_reg;

    frame_state_t        state_reg, state_next;
    logic [DIGITS-1:0]   seen_reg, seen_next;
    logic                frame_load;

    assign sample_in = {an_n, seg_n};

    // Accept is registered, so the decode below always works on smp_reg,
    // which still holds the stable value during the accept cycle.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = 8'd0;
        end else if (sample_in == smp_reg) begin
            if (cnt_reg != STABLE_LIMIT) begin
                cnt_next = cnt_reg + 8'd1;
            end
        end else begin
            cnt_next = 8'd0;
        end
        accept_next = !clr && (cnt_next == STABLE_LIMIT) && (cnt_reg != STABLE_LIMIT);
    end

    assign an_low     = ~smp_reg[SMP_W-1:7];
    assign multi_low  = (an_low & (an_low - 1'b1)) != '0;
    assign single_low = (an_low != '0) && !multi_low;
    assign accept_act = accept_reg && !clr;
    assign single_act = accept_act && single_low;

    seven_seg_pattern_lookup u_lookup (
        .pattern (smp_reg[6:0]),
        .legal   (code_legal),
        .nibble  (code_nibble)
    );

    // Illegal codes keep the old nibble but drop the valid flag.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign digit_hit[gi] = single_act && an_low[gi];
        assign digits_next[4*gi +: 4] =
            clr                           ? 4'h0        :
            (digit_hit[gi] && code_legal) ? code_nibble :
                                            digits_reg[4*gi +: 4];
        assign digit_valid_next[gi] =
            clr           ? 1'b0       :
            digit_hit[gi] ? code_legal :
                            digit_valid_reg[gi];
    end

    always_comb begin
        state_next = state_reg;
        seen_next  = seen_reg;
        frame_load = 1'b0;
        case (state_reg)
            SCAN: begin
                seen_next = seen_reg | digit_hit;
                if (seen_next == '1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                seen_next  = digit_hit;
                frame_load = 1'b1;
                state_next = SCAN;
            end
            default: state_next = SCAN;
        endcase
        if (clr) begin
            seen_next  = '0;
            frame_load = 1'b0;
            state_next = SCAN;
        end
    end

    assign frame_next = clr        ? '0         :
                        frame_load ? digits_reg :
                                     frame_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= SCAN;
            seen_reg  <= '0;
        end else begin
            state_reg <= state_next;
            seen_reg  <= seen_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_reg         <= SMP_IDLE;
            cnt_reg         <= 8'd0;
            accept_reg      <= 1'b0;
            digits_reg      <= '0;
            digit_valid_reg <= '0;
            frame_reg       <= '0;
            frame_valid_reg <= 1'b0;
            code_err_reg    <= 1'b0;
            anode_err_reg   <= 1'b0;
        end else begin
            smp_reg         <= sample_in;
            cnt_reg         <= cnt_next;
            accept_reg      <= accept_next;
            digits_reg      <= digits_next;
            digit_valid_reg <= digit_valid_next;
            frame_reg       <= frame_next;
            frame_valid_reg <= frame_load;
            code_err_reg    <= single_act && !code_legal;
            anode_err_reg   <= accept_act && multi_low;
        end
    end

    assign digits      = digits_reg;
    assign digit_valid = digit_valid_reg;
    assign frame       = frame_reg;
    assign frame_valid = frame_valid_reg;
    assign code_err    = code_err_reg;
    assign anode_err   = anode_err_reg;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench: stimulus pushes expected pulse events from a behavioural
// model; a negedge monitor pops and compares whenever the DUT pulses.
module tb_seven_seg_capture;

    localparam int S        = 4;
    localparam int EV_CODE  = 0;
    localparam int EV_ANODE = 1;
    localparam int EV_FRAME = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  an_n  = 4'hF;
    logic [15:0] digits, frame;
    logic [3:0]  digit_valid;
    logic        frame_valid, code_err, anode_err;

    seven_seg_capture #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .clr         (clr),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame       (frame),
        .frame_valid (frame_valid),
        .code_err    (code_err),
        .anode_err   (anode_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [15:0] digits;
        logic [3:0]  valid;
        logic [15:0] frame;
    } ev_t;

    ev_t         exp_q[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [15:0] m_digits = '0;
    logic [15:0] m_frame  = '0;
    logic [3:0]  m_valid  = '0;
    logic [3:0]  m_seen   = '0;
    logic [10:0] last_in  = 11'h7FF;

    logic [6:0] code_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    string ev_name [3] = '{"code_err", "anode_err", "frame_valid"};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind);
        ev_t e;
        e.kind   = kind;
        e.digits = m_digits;
        e.valid  = m_valid;
        e.frame  = m_frame;
        exp_q.push_back(e);
    endtask

    // Reference behaviour of one accepted bus sample.
    task automatic model_accept(input logic [3:0] an, input logic [6:0] seg);
        int lows, idx, nib;
        bit legal;
        lows = $countones(~an);
        if (lows == 0) return;
        if (lows > 1) begin
            push_ev(EV_ANODE);
            return;
        end
        idx = 0;
        for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
        legal = 1'b0;
        nib   = 0;
        for (int c = 0; c < 16; c++) if (code_tab[c] == seg) begin legal = 1'b1; nib = c; end
        if (legal) begin
            m_digits[4*idx +: 4] = 4'(nib);
            m_valid[idx] = 1'b1;
        end else begin
            m_valid[idx] = 1'b0;
            push_ev(EV_CODE);
        end
        m_seen[idx] = 1'b1;
        if (m_seen == 4'hF) begin
            m_frame = m_digits;
            m_seen  = '0;
            push_ev(EV_FRAME);
        end
    endtask

    task automatic model_clear();
        m_digits = '0;
        m_valid  = '0;
        m_frame  = '0;
        m_seen   = '0;
    endtask

    // Called at posedge+1; the value is present at the next n rising edges.
    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_n    = an;
        seg_n   = seg;
        last_in = {an, seg};
        if (n >= S + 1) model_accept(an, seg);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_event(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL unexpected_%s: got pulse, expected none", ev_name[kind]);
            return;
        end
        e = exp_q.pop_front();
        $display("[%0t] %s digits=%h valid=%b frame=%h", $time, ev_name[kind], digits, digit_valid, frame);
        check("event_kind", kind, e.kind);
        check("event_digits", digits, e.digits);
        check("event_valid", digit_valid, e.valid);
        check("event_frame", frame, e.frame);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (code_err)    check_event(EV_CODE);
            if (anode_err)   check_event(EV_ANODE);
            if (frame_valid) check_event(EV_FRAME);
        end
    end

    initial begin : stimulus
        int          n;
        logic [3:0]  an;
        logic [6:0]  seg;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_digits", digits, 16'h0);
        check("reset_valid", digit_valid, 4'h0);
        check("reset_frame", frame, 16'h0);
        check("reset_frame_valid", frame_valid, 1'b0);
        check("reset_code_err", code_err, 1'b0);
        check("reset_anode_err", anode_err, 1'b0);

        // Full frame 3-2-1-0
        hold(4'b1110, 7'b0000001, 6);
        hold(4'b1101, 7'b1001111, 6);
        hold(4'b1011, 7'b0010010, 6);
        hold(4'b0111, 7'b0000110, 6);
        hold(4'hF, 7'h7F, 4);
        check("full_digits", digits, 16'h3210);
        check("full_valid", digit_valid, 4'hF);
        check("full_frame", frame, 16'h3210);

        // Glitch: E too short, 8 accepted
        hold(4'b1110, 7'b0110000, 4);
        hold(4'b1110, 7'b0000000, 6);
        hold(4'hF, 7'h7F, 4);
        check("glitch_digit0", digits[3:0], 4'h8);

        // Illegal code on digit 2
        hold(4'b1011, 7'b1111110, 8);
        hold(4'hF, 7'h7F, 4);
        check("illegal_valid2", digit_valid[2], 1'b0);
        check("illegal_digit2", digits[11:8], 4'h2);

        // Multiple anodes, then lit segments with blank anodes
        hold(4'b1100, 7'b0001000, 6);
        hold(4'hF, 7'b0000000, 6);
        hold(4'hF, 7'h7F, 4);
        check("anode_digits", digits, m_digits);
        check("anode_valid", digit_valid, m_valid);

        // clr coincides with the accept that would complete the frame
        hold(4'b1101, 7'b0001111, 6);
        an_n    = 4'b0111;
        seg_n   = 7'b0000110;
        last_in = {an_n, seg_n};
        repeat (S + 1) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        model_clear();
        hold(4'hF, 7'h7F, 6);
        check("clr_digits", digits, 16'h0);
        check("clr_valid", digit_valid, 4'h0);
        check("clr_frame", frame, 16'h0);

        // Async reset mid-window
        hold(4'b1101, 7'b0001000, 6);
        check("pre_reset_digits", digits, 16'h00A0);
        an_n    = 4'b1110;
        seg_n   = 7'b0100100;
        last_in = {an_n, seg_n};
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_digits", digits, 16'h0);
        check("async_valid", digit_valid, 4'h0);
        check("async_frame", frame, 16'h0);
        check("async_pulses", {frame_valid, code_err, anode_err}, 3'b000);
        model_clear();
        #2 rst = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (digits[3:0] == 4'h5) break;
        end
        check("reset_latency", n, S + 2);
        model_accept(4'b1110, 7'b0100100);

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            do begin
                n = $urandom_range(0, 9);
                if (n == 0) begin
                    an = 4'hF;
                end else if (n == 1) begin
                    do an = 4'($urandom_range(0, 15)); while ($countones(~an) < 2);
                end else begin
                    an = ~(4'b0001 << $urandom_range(0, 3));
                end
                if ($urandom_range(0, 4) == 0) seg = 7'($urandom);
                else                          seg = code_tab[$urandom_range(0, 15)];
            end while ({an, seg} == last_in);
            hold(an, seg, $urandom_range(2, S + 4));
        end
        hold(4'hF, 7'h7F, 10);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_digits", digits, m_digits);
        check("final_valid", digit_valid, m_valid);
        check("final_frame", frame, m_frame);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
